// File: rtl/led_pwm_bank_pkg.sv
// Shared types and register-map constants for the LED PWM bank.
package led_pwm_bank_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    // Register offsets within the 256-byte bus window
    localparam logic [7:0] OFF_GLOBAL    = 8'h00;
    localparam logic [7:0] OFF_BLINK     = 8'h04;
    localparam logic [7:0] OFF_STATUS    = 8'h08;
    localparam logic [7:0] OFF_CHAN_BASE = 8'h40;

    // Field bit positions
    localparam int GLOBAL_EN_BIT       = 0;
    localparam int GLOBAL_PRESCALE_LSB = 16;
    localparam int BLINK_HALF_LSB      = 0;
    localparam int BLINK_HALF_BITS     = 16;
    localparam int STATUS_PHASE_BIT    = 0;
    localparam int STATUS_LED_LSB      = 16;
    localparam int CHAN_MODE_LSB       = 0;
    localparam int CHAN_DUTY_LSB       = 8;

    // Expand per-byte write strobes into a 32-bit bit mask
    function automatic logic [31:0] strobe_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/led_pwm_bank_if.sv
// picorv32 iomem bus bundle between the SoC core and the LED bank.
interface led_pwm_bank_if;

    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );

endinterface

// File: rtl/led_pwm_bank_channel.sv
// One LED channel: selects the drive level from its mode and the shared
// PWM counter / blink phase.
module led_channel
    import led_pwm_bank_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  mode_e               mode,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                blink_phase,
    input  logic                enable,
    output logic                on
);

    // Channel drive decision; a disabled bank forces the channel off
    always_comb begin
        // NOTE: default assignment first so no path leaves 'on' unassigned (no latch).
        on = 1'b0;
        if (enable) begin
            case (mode)
                MODE_OFF:   on = 1'b0;
                MODE_ON:    on = 1'b1;
                MODE_BLINK: on = blink_phase;
                MODE_PWM:   on = (pwm_cnt < duty);
                default:    on = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/led_pwm_bank.sv
// Memory-mapped LED bank: NUM_LEDS channels, each off/on/blink/PWM, driven
// from a shared tick prescaler, PWM counter and blink phase.
module led_pwm_bank
    import led_pwm_bank_pkg::*;
#(
    parameter int          NUM_LEDS      = 8,
    parameter int          PWM_BITS      = 8,
    parameter int          PRESCALE_BITS = 16,
    parameter logic [31:0] ADDR_BASE     = 32'h0300_0000
) (
    input  logic                clk,
    input  logic                resetn,
    led_pwm_bank_if.slave       bus,
    output logic [NUM_LEDS-1:0] led
);

    logic                     enable;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [PRESCALE_BITS-1:0] pre_cnt;
    logic [15:0]              half_period;
    logic [15:0]              blink_cnt;
    logic                     blink_phase;
    logic [PWM_BITS-1:0]      pwm_cnt;
    mode_e                    chan_mode [NUM_LEDS];
    logic [PWM_BITS-1:0]      chan_duty [NUM_LEDS];
    logic [NUM_LEDS-1:0]      chan_on;
    logic                     tick;

    logic [7:0]  offset;
    logic [3:0]  chan_idx;
    logic        in_window;
    logic        req;
    logic        wr_en;
    logic        is_chan;
    logic [31:0] rd_word;
    logic [31:0] wr_word;

    assign offset    = bus.iomem_addr[7:0];
    assign chan_idx  = offset[5:2];
    assign in_window = (bus.iomem_addr[31:8] == ADDR_BASE[31:8]);
    // A request is only accepted while no ack is outstanding
    assign req       = bus.iomem_valid && in_window && !bus.iomem_ready;
    assign wr_en     = req && (bus.iomem_wstrb != 4'b0000);
    assign is_chan   = (offset[7:6] == OFF_CHAN_BASE[7:6]) && (offset[1:0] == 2'b00)
                       && ({1'b0, chan_idx} < 5'(NUM_LEDS));

    // Current image of the addressed register; unimplemented bits stay 0
    always_comb begin
        rd_word = '0;
        if (is_chan) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (chan_idx == 4'(i)) begin
                    rd_word[CHAN_MODE_LSB +: 2]        = chan_mode[i];
                    rd_word[CHAN_DUTY_LSB +: PWM_BITS] = chan_duty[i];
                end
            end
        end else begin
            case (offset)
                OFF_GLOBAL: begin
                    rd_word[GLOBAL_EN_BIT]                          = enable;
                    rd_word[GLOBAL_PRESCALE_LSB +: PRESCALE_BITS]   = prescale;
                end
                OFF_BLINK:  rd_word[BLINK_HALF_LSB +: BLINK_HALF_BITS] = half_period;
                OFF_STATUS: begin
                    rd_word[STATUS_PHASE_BIT]              = blink_phase;
                    rd_word[STATUS_LED_LSB +: NUM_LEDS]    = led;
                end
                default: ;
            endcase
        end
    end

    // Byte-strobe merge: untouched bytes keep the register's current value
    assign wr_word = (rd_word & ~strobe_mask(bus.iomem_wstrb))
                   | (bus.iomem_wdata & strobe_mask(bus.iomem_wstrb));

    // Configuration registers, committed at the edge ending the request cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            enable      <= 1'b0;
            prescale    <= '0;
            half_period <= '0;
            // NOTE: the per-channel arrays are small flop banks, not RAM, so they reset with the rest.
            for (int i = 0; i < NUM_LEDS; i++) begin
                chan_mode[i] <= MODE_OFF;
                chan_duty[i] <= '0;
            end
        end else if (wr_en) begin
            if (is_chan) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (chan_idx == 4'(i)) begin
                        chan_mode[i] <= mode_e'(wr_word[CHAN_MODE_LSB +: 2]);
                        chan_duty[i] <= wr_word[CHAN_DUTY_LSB +: PWM_BITS];
                    end
                end
            end else begin
                case (offset)
                    OFF_GLOBAL: begin
                        enable   <= wr_word[GLOBAL_EN_BIT];
                        prescale <= wr_word[GLOBAL_PRESCALE_LSB +: PRESCALE_BITS];
                    end
                    OFF_BLINK: half_period <= wr_word[BLINK_HALF_LSB +: BLINK_HALF_BITS];
                    default: ;
                endcase
            end
        end
    end

    // One-cycle ack with read data captured from the request cycle
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
        end else begin
            bus.iomem_ready <= req;
            bus.iomem_rdata <= req ? rd_word : '0;
        end
    end

    assign tick = enable && (pre_cnt == prescale);

    // Prescaler, PWM counter and blink phase; all held at 0 while disabled
    always_ff @(posedge clk) begin
        if (!resetn || !enable) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_BITS'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                if (blink_cnt == half_period) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_channel #(.PWM_BITS(PWM_BITS)) u_chan (
            .mode        (chan_mode[g]),
            .duty        (chan_duty[g]),
            .pwm_cnt     (pwm_cnt),
            .blink_phase (blink_phase),
            .enable      (enable),
            .on          (chan_on[g])
        );
    end

    // Registered LED drive toward the board output buffers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led <= '0;
        end else begin
            led <= chan_on;
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed self-checking bench for led_pwm_bank (default parameters).
module tb_led_pwm_bank;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] led;
    int         n_cmp = 0;
    int         n_fail = 0;

    led_pwm_bank_if bus ();

    led_pwm_bank dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .led    (led)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access; lat = cycles from valid to ready, -1 if never acked
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
        @(posedge clk); #1;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wdata = wdata;
        bus.iomem_wstrb = wstrb;
        lat   = -1;
        rdata = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (bus.iomem_ready) begin
                lat   = i;
                rdata = bus.iomem_rdata;
                break;
            end
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input string tag);
        logic [31:0] d;
        int          lat;
        bus_xfer(addr, data, strb, d, lat);
        check({tag, "_ack"}, 32'(lat), 32'd1);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        int          lat;
        bus_xfer(addr, 32'h0, 4'h0, d, lat);
        check({tag, "_ack"}, 32'(lat), 32'd1);
        check(tag, d, exp);
    endtask

    // Cycles until led[idx] changes, -1 if not within 40 cycles
    task automatic wait_change(input int idx, output int cycles);
        logic prev;
        prev   = led[idx];
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (led[idx] !== prev) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic count_high(input int idx, input int span, output int highs);
        highs = 0;
        for (int i = 0; i < span; i++) begin
            @(posedge clk); #1;
            if (led[idx]) highs++;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  pattern;
        int          lat;
        int          cyc;
        int          highs;

        bus.iomem_valid = 1'b0;
        bus.iomem_addr  = '0;
        bus.iomem_wdata = '0;
        bus.iomem_wstrb = 4'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_ready", 32'(bus.iomem_ready), 32'h0);
        check("rst_rdata", bus.iomem_rdata, 32'h0);
        resetn = 1'b1;
        rd(BASE + 32'h00, 32'h0, "rd_global_rst");
        rd(BASE + 32'h08, 32'h0, "rd_status_rst");
        check("led_after_rst_reads", 32'(led), 32'h0);

        // Held valid: ready pulses every other cycle, never two in a row
        @(posedge clk); #1;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = BASE + 32'h00;
        bus.iomem_wstrb = 4'h0;
        pattern = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pattern[3 - i] = bus.iomem_ready;
        end
        bus.iomem_valid = 1'b0;
        check("held_valid_ready", 32'(pattern), 32'hA);

        // Enable, then CHAN3 on: led appears two cycles after the request cycle
        wr(BASE + 32'h00, 32'h0000_0001, 4'hF, "wr_global_en");
        wr(BASE + 32'h4C, 32'h0000_0001, 4'hF, "wr_chan3_on");
        check("chan3_led_n1", 32'(led), 32'h00);
        @(posedge clk); #1;
        check("chan3_led_n2", 32'(led), 32'h08);

        // Byte-1 only write: duty updates, mode unchanged
        wr(BASE + 32'h4C, 32'h0000_5502, 4'b0010, "wr_chan3_strb");
        repeat (2) @(posedge clk);
        #1;
        check("chan3_strb_led", 32'(led), 32'h08);
        rd(BASE + 32'h4C, 32'h0000_5501, "rd_chan3_strb");

        // PWM on CHAN0 with P=0
        wr(BASE + 32'h40, 32'h0000_4003, 4'hF, "wr_chan0_d64");
        repeat (2) @(posedge clk);
        count_high(0, 256, highs);
        check("pwm_d64", 32'(highs), 32'd64);
        wr(BASE + 32'h40, 32'h0000_0003, 4'hF, "wr_chan0_d0");
        repeat (2) @(posedge clk);
        count_high(0, 256, highs);
        check("pwm_d0", 32'(highs), 32'd0);
        wr(BASE + 32'h40, 32'h0000_FF03, 4'hF, "wr_chan0_d255");
        repeat (2) @(posedge clk);
        count_high(0, 256, highs);
        check("pwm_d255", 32'(highs), 32'd255);

        // Blink: P=3, H=2 -> toggle every 12 cycles
        wr(BASE + 32'h40, 32'h0000_0000, 4'hF, "wr_chan0_off");
        wr(BASE + 32'h00, 32'h0003_0001, 4'hF, "wr_global_p3");
        wr(BASE + 32'h04, 32'h0000_0002, 4'hF, "wr_blink_h2");
        rd(BASE + 32'h04, 32'h0000_0002, "rd_blink");
        wr(BASE + 32'h44, 32'h0000_0002, 4'hF, "wr_chan1_blink");
        wait_change(1, cyc);
        check("blink_sync1", 32'(cyc != -1), 32'd1);
        wait_change(1, cyc);
        check("blink_sync2", 32'(cyc != -1), 32'd1);
        wait_change(1, cyc);
        check("blink_period_a", 32'(cyc), 32'd12);
        wait_change(1, cyc);
        check("blink_period_b", 32'(cyc), 32'd12);
        if (led[1] !== 1'b1) wait_change(1, cyc);
        check("blink_reach_on", 32'(led[1]), 32'd1);
        rd(BASE + 32'h08, 32'h000A_0001, "status_phase1");
        wait_change(1, cyc);
        check("blink_reach_off", 32'(led[1]), 32'd0);
        rd(BASE + 32'h08, 32'h0008_0000, "status_phase0");

        // Reset mid-PWM with a request pending
        wr(BASE + 32'h40, 32'h0000_8003, 4'hF, "wr_chan0_d128");
        wr(BASE + 32'h00, 32'h0000_0001, 4'hF, "wr_global_p0");
        @(posedge clk); #1;
        resetn          = 1'b0;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = BASE + 32'h00;
        bus.iomem_wstrb = 4'h0;
        @(posedge clk); #1;
        check("midrst_led", 32'(led), 32'h0);
        check("midrst_ready", 32'(bus.iomem_ready), 32'h0);
        resetn          = 1'b1;
        bus.iomem_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_no_ack", 32'(bus.iomem_ready), 32'h0);
        rd(BASE + 32'h00, 32'h0, "postrst_global");
        rd(BASE + 32'h04, 32'h0, "postrst_blink");
        rd(BASE + 32'h40, 32'h0, "postrst_chan0");
        rd(BASE + 32'h4C, 32'h0, "postrst_chan3");
        rd(BASE + 32'h08, 32'h0, "postrst_status");

        // Out-of-window access is never acked
        bus_xfer(BASE + 32'h100, 32'h0, 4'h0, d, lat);
        check("oow_no_ack", 32'(lat), 32'hFFFF_FFFF);

        // Unimplemented channel offset: acked, reads 0, no effect
        wr(BASE + 32'h00, 32'h0000_0001, 4'hF, "wr_global_en2");
        wr(BASE + 32'h7C, 32'hFFFF_FFFF, 4'hF, "wr_off7c");
        rd(BASE + 32'h7C, 32'h0, "rd_off7c");
        check("off7c_led", 32'(led), 32'h0);
        rd(BASE + 32'h00, 32'h0000_0001, "rd_global_after7c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
